// File: rtl/primitive_rasterizer.sv
// Triangle-list rasterizer: collects three transformed vertices and walks the clipped
// bounding box one candidate per cycle, emitting covered pixels through a ready/valid output.
module primitive_rasterizer #(
  parameter int SCREEN_W     = 256,
  parameter int SCREEN_H     = 256,
  parameter int COORD_W      = 9,
  parameter int OPCODE_WIDTH = 8,
  parameter int VREG_WIDTH   = 64,
  parameter logic [OPCODE_WIDTH-1:0] OP_BEGINPRIMITIVE = OPCODE_WIDTH'(16),
  parameter logic [OPCODE_WIDTH-1:0] OP_ENDPRIMITIVE   = OPCODE_WIDTH'(17),
  parameter logic [OPCODE_WIDTH-1:0] OP_SETCOLOR       = OPCODE_WIDTH'(18),
  parameter logic [OPCODE_WIDTH-1:0] OP_SETVERTEX      = OPCODE_WIDTH'(19)
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET_N,
  input  logic                    I_LOCK,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [VREG_WIDTH-1:0]   I_VOut,
  input  logic [VREG_WIDTH-1:0]   I_ColorOut,
  input  logic                    I_PixelReady,
  output logic                    O_FRAMESTALL,
  output logic                    O_PixelValid,
  output logic [COORD_W-2:0]      O_PixelX,
  output logic [COORD_W-2:0]      O_PixelY,
  output logic [VREG_WIDTH-1:0]   O_PixelColor,
  output logic                    O_PrimDone,
  output logic                    O_LOCK
);
  localparam int EW = 24;
  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [EW-1:0] edge_t;
  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DRAIN} state_t;

  localparam coord_t X_LAST = coord_t'(SCREEN_W - 1);
  localparam coord_t Y_LAST = coord_t'(SCREEN_H - 1);
  localparam coord_t ZERO   = coord_t'(0);

  function automatic edge_t edge_fn(input coord_t xa, input coord_t ya, input coord_t xb,
                                    input coord_t yb, input coord_t x, input coord_t y);
    edge_t wxa, wya, wxb, wyb, wx, wy;
    wxa = xa; wya = ya; wxb = xb; wyb = yb; wx = x; wy = y;
    return (wx - wxa) * (wyb - wya) - (wy - wya) * (wxb - wxa);
  endfunction

  function automatic coord_t min2(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t max2(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

  // Either winding is accepted; zero counts on both sides so edges are inclusive.
  function automatic logic covered(input edge_t e0, input edge_t e1, input edge_t e2);
    logic all_nonneg, all_nonpos;
    all_nonneg = !e0[EW-1] && !e1[EW-1] && !e2[EW-1];
    all_nonpos = (e0[EW-1] || e0 == '0) && (e1[EW-1] || e1 == '0) && (e2[EW-1] || e2 == '0);
    return all_nonneg || all_nonpos;
  endfunction

  state_t                  state;
  logic [1:0]              count;
  logic                    in_prim;
  logic [VREG_WIDTH-1:0]   cur_color, tri_color;
  coord_t                  vx [3];
  coord_t                  vy [3];
  coord_t                  xmin, xmax, ymin, ymax, cx, cy;

  coord_t in_x, in_y, bx_lo, bx_hi, by_lo, by_hi;
  edge_t  area, e0, e1, e2;
  logic   out_free;
  logic   unused_vout;

  assign O_LOCK = I_LOCK;

  // Q8.7 to integer pixel: keep the integer bits of each 16-bit field.
  assign in_x = I_VOut[23 +: COORD_W];
  assign in_y = I_VOut[39 +: COORD_W];
  assign unused_vout = ^{I_VOut[VREG_WIDTH-1:48], I_VOut[38:32], I_VOut[22:0]};

  assign bx_lo = max2(min2(min2(vx[0], vx[1]), vx[2]), ZERO);
  assign bx_hi = min2(max2(max2(vx[0], vx[1]), vx[2]), X_LAST);
  assign by_lo = max2(min2(min2(vy[0], vy[1]), vy[2]), ZERO);
  assign by_hi = min2(max2(max2(vy[0], vy[1]), vy[2]), Y_LAST);
  assign area  = edge_fn(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]);

  assign e0 = edge_fn(vx[0], vy[0], vx[1], vy[1], cx, cy);
  assign e1 = edge_fn(vx[1], vy[1], vx[2], vy[2], cx, cy);
  assign e2 = edge_fn(vx[2], vy[2], vx[0], vy[0], cx, cy);

  assign out_free = !O_PixelValid || I_PixelReady;

  always_ff @(negedge I_CLOCK) begin
    if (!I_RESET_N) begin
      state        <= IDLE;
      count        <= 2'd0;
      in_prim      <= 1'b0;
      cur_color    <= '0;
      O_FRAMESTALL <= 1'b0;
      O_PixelValid <= 1'b0;
      O_PixelX     <= '0;
      O_PixelY     <= '0;
      O_PixelColor <= '0;
      O_PrimDone   <= 1'b0;
    end else begin
      O_PrimDone <= 1'b0;
      case (state)
        IDLE: begin
          if (I_LOCK) begin
            if (I_Opcode == OP_BEGINPRIMITIVE) begin
              in_prim <= 1'b1;
              count   <= 2'd0;
            end else if (I_Opcode == OP_ENDPRIMITIVE) begin
              in_prim <= 1'b0;
              count   <= 2'd0;
            end else if (I_Opcode == OP_SETCOLOR) begin
              cur_color <= I_ColorOut;
            end else if (I_Opcode == OP_SETVERTEX && in_prim) begin
              vx[count] <= in_x;
              vy[count] <= in_y;
              if (count == 2'd2) begin
                count        <= 2'd0;
                tri_color    <= cur_color;
                state        <= SETUP;
                O_FRAMESTALL <= 1'b1;
              end else begin
                count <= count + 2'd1;
              end
            end
          end
        end
        // Setup: bounding box and degenerate rejection
        SETUP: begin
          xmin <= bx_lo;
          xmax <= bx_hi;
          ymin <= by_lo;
          ymax <= by_hi;
          cx   <= bx_lo;
          cy   <= by_lo;
          if (area == '0 || bx_lo > bx_hi || by_lo > by_hi) begin
            O_PrimDone   <= 1'b1;
            O_FRAMESTALL <= 1'b0;
            state        <= IDLE;
          end else begin
            state <= SCAN;
          end
        end
        // Scan: one candidate per free output slot, x fastest
        SCAN: begin
          if (out_free) begin
            if (covered(e0, e1, e2)) begin
              O_PixelValid <= 1'b1;
              O_PixelX     <= cx[COORD_W-2:0];
              O_PixelY     <= cy[COORD_W-2:0];
              O_PixelColor <= tri_color;
            end else begin
              O_PixelValid <= 1'b0;
            end
            if (cx == xmax && cy == ymax) begin
              state <= DRAIN;
            end else if (cx == xmax) begin
              cx <= xmin;
              cy <= cy + coord_t'(1);
            end else begin
              cx <= cx + coord_t'(1);
            end
          end
        end
        DRAIN: begin
          if (out_free) begin
            O_PixelValid <= 1'b0;
            O_PrimDone   <= 1'b1;
            O_FRAMESTALL <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/primitive_rasterizer.md
Name: primitive_rasterizer

Overview:
- Sits directly downstream of the vertex transform stage.
- Consumes its transformed vertices (Q8.7 x/y in a 64-bit vreg), colours and opcodes.
- Assembles triangles between BEGINPRIMITIVE/ENDPRIMITIVE and scans each triangle's clipped bounding box, emitting one covered pixel per accepted handshake.
- Back-pressures the vertex stage through its frame-stall input while a triangle is being set up or scanned.

Parameters:
SCREEN_W, 256, horizontal pixel count; x clipped to [0, SCREEN_W-1]
SCREEN_H, 256, vertical pixel count; y clipped to [0, SCREEN_H-1]
COORD_W, 9, signed integer pixel coordinate width after Q8.7 truncation

Ports:
I_CLOCK  in  1  single clock; all state updates on its falling edge, matching the pipeline
I_RESET_N  in  1  synchronous active-low reset
I_LOCK  in  1  upstream valid/lock; inputs consumed only when high
I_Opcode  in  OPCODE_WIDTH  opcode from vertex stage
I_VOut  in  VREG_WIDTH  transformed vertex; [31:16]=x, [47:32]=y, signed Q8.7
I_ColorOut  in  VREG_WIDTH  colour from vertex stage
I_PixelReady  in  1  downstream accepts pixel
O_FRAMESTALL  out  1  stall to vertex stage (drives its I_FRAMESTALL)
O_PixelValid  out  1  pixel outputs valid
O_PixelX  out  COORD_W-1  pixel x (unsigned, clipped)
O_PixelY  out  COORD_W-1  pixel y (unsigned, clipped)
O_PixelColor  out  VREG_WIDTH  triangle colour
O_PrimDone  out  1  one-cycle pulse when a triangle finishes, including empty ones
O_LOCK  out  1  equals I_LOCK

Behaviour:
- Reset (I_RESET_N=0 at an edge):
  - state=IDLE; all outputs 0; vertex count 0; current colour 0; in_primitive 0.
  - Takes effect mid-SCAN or mid-DRAIN; any held pixel is dropped.
- O_FRAMESTALL is registered: 1 iff state is not IDLE.
- Input consumption happens only in IDLE with I_LOCK=1.
  - BEGINPRIMITIVE: in_primitive=1, count=0.
  - ENDPRIMITIVE: in_primitive=0, count=0; a partial triangle is discarded with no O_PrimDone.
  - SETCOLOR: current colour = I_ColorOut.
  - SETVERTEX with in_primitive=1: store integer coords (x = I_VOut[31:16]>>>7, y = I_VOut[47:32]>>>7, arithmetic) into slot[count], count++.
  - On the 3rd vertex: latch current colour as triangle colour, count=0, go to SETUP (triangle-list semantics).
  - SETVERTEX with in_primitive=0: ignored.
  - All other opcodes: ignored.
- SETUP (1 cycle):
  - Edge functions: Ei(x,y) = (x-xa)*(yb-ya) - (y-ya)*(xb-xa) over edges (v0,v1), (v1,v2), (v2,v0); evaluate in 24-bit signed.
  - area = E0 evaluated at v2.
  - bbox = min/max of vertex coords, clamped to the screen.
  - If area==0 or the clamped bbox is empty (min>max): pulse O_PrimDone next cycle, go to IDLE.
  - Otherwise cursor=(xmin,ymin), go to SCAN.
- SCAN:
  - Order: x fastest, then y, one candidate per edge when the output register is free (O_PixelValid=0, or O_PixelValid=1 and I_PixelReady=1).
  - Inside test: all three Ei>=0, or all <=0. This accepts either winding; edges are inclusive.
  - Inside: load X/Y/colour, O_PixelValid=1. Outside: O_PixelValid=0.
  - Advance the cursor. At (xmax,ymax), go to DRAIN instead of advancing.
  - O_PixelValid=1 with I_PixelReady=0: the cursor and outputs hold stable.
- DRAIN:
  - Wait until O_PixelValid=0, or the pixel is accepted. Then O_PixelValid=0, pulse O_PrimDone for one cycle, go to IDLE.
- Timing with I_PixelReady held high: 1 SETUP cycle, N bbox SCAN cycles, 1 DRAIN cycle; O_PrimDone is high on the edge after DRAIN.
- The upstream instruction presented at the edge that entered SETUP is held by the stall and consumed once on return to IDLE.

Test Plan:
- BEGIN; SETCOLOR 0x00FF00FF00FF00FF; vertices (0,0), (4,0), (0,4), i.e. x/y fields 0x0000/0x0200; ready=1 -> exactly 15 pixels satisfying x+y<=4, raster order, colour matches. O_PrimDone 28 cycles after the 3rd vertex. O_FRAMESTALL high throughout.
- Same triangle, reversed winding (0,0), (0,4), (4,0) -> identical 15 pixels.
- Degenerate (0,0), (2,2), (4,4) -> zero pixels; O_PrimDone 2 cycles after the 3rd vertex.
- Vertices (-3,0), (2,0), (-3,5) -> bbox clamped to x 0..2, y 0..5; only on-screen covered pixels emitted, none with x<0.
- First triangle with I_PixelReady toggling 1,0,0,1 -> valid pixels hold stable for 2 cycles; same 15 pixels, none lost or duplicated.
- I_RESET_N=0 for 1 edge mid-SCAN -> next cycle: O_PixelValid=0, O_FRAMESTALL=0, no O_PrimDone. Then 2 vertices + ENDPRIMITIVE -> no output.
